// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Synchronises and debounces GPIO pins, latches rising/falling edges into
// write-1-to-clear capture registers and exposes everything on the shared
// data bus (mode 00 idle, 01 read, 10 write, 11 idle).
// Optional feature macro: GPIO_COND_IRQ_EN (adds MASK storage and the level irq).
module gpio_input_conditioner #(
   parameter int          WIDTH          = 16,
   parameter logic [31:0] BASE_ADDR      = 32'h4034,
   parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_raw,
   output logic [WIDTH-1:0] pins_clean,
   inout  wire  [31:0]      data_bus_data,
   input  logic [31:0]      data_bus_addr,
   input  logic [1:0]       data_bus_mode,
   output logic             irq
);

   logic [WIDTH-1:0]       sync1_q;
   logic [WIDTH-1:0]       sync_q;
   logic [WIDTH-1:0]       stable_q;
   logic [WIDTH-1:0]       stable_next;
   logic [WIDTH-1:0][15:0] cnt_q;
   logic [WIDTH-1:0][15:0] cnt_next;
   logic [15:0]            period_q;
   logic [WIDTH-1:0]       rise_q;
   logic [WIDTH-1:0]       fall_q;
   logic [WIDTH-1:0]       rise_set;
   logic [WIDTH-1:0]       fall_set;
   logic [WIDTH-1:0]       rise_clr;
   logic [WIDTH-1:0]       fall_clr;
   logic [WIDTH-1:0]       mask_rd;
   logic [WIDTH-1:0]       wdata;
   logic [31:0]            offset;
   logic [31:0]            rdata;
   logic                   in_range;
   logic                   rd_en;
   logic                   wr_en;
   logic                   wr_period;
   logic                   unused_bits;

   assign offset    = data_bus_addr - BASE_ADDR;
   assign in_range  = (offset < 32'd5);
   assign rd_en     = (data_bus_mode == 2'b01) && in_range;
   assign wr_en     = (data_bus_mode == 2'b10) && in_range;
   assign wr_period = wr_en && (offset[2:0] == 3'd1);
   assign wdata     = data_bus_data[WIDTH-1:0];
   assign rise_clr  = (wr_en && (offset[2:0] == 3'd2)) ? wdata : '0;
   assign fall_clr  = (wr_en && (offset[2:0] == 3'd3)) ? wdata : '0;
   assign rise_set  = stable_next & ~stable_q;
   assign fall_set  = ~stable_next & stable_q;
   assign pins_clean = stable_q;
   assign unused_bits = ^{data_bus_data, offset};

   // Two-flop synchroniser per pin; sync_q is the metastability-safe level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync_q  <= '0;
      end else begin
         sync1_q <= pins_raw;
         sync_q  <= sync1_q;
      end
   end

   // Per-pin debounce counter: a new level must persist past PERIOD counts; a PERIOD write restarts every count
   always_comb begin
      stable_next = stable_q;
      cnt_next    = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (wr_period) begin
            cnt_next[i] = '0;
         end else if (sync_q[i] == stable_q[i]) begin
            cnt_next[i] = '0;
         end else if (cnt_q[i] >= period_q) begin
            stable_next[i] = sync_q[i];
            cnt_next[i]    = '0;
         end else if (cnt_q[i] != 16'hFFFF) begin
            cnt_next[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   // Debounced state, period register and edge captures (a new capture beats a same-edge clear)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q <= '0;
         cnt_q    <= '0;
         period_q <= DEFAULT_PERIOD;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         stable_q <= stable_next;
         cnt_q    <= cnt_next;
         if (wr_period) begin
            period_q <= data_bus_data[15:0];
         end
         rise_q <= (rise_q & ~rise_clr) | rise_set;
         fall_q <= (fall_q & ~fall_clr) | fall_set;
      end
   end

`ifdef GPIO_COND_IRQ_EN
   logic [WIDTH-1:0] mask_q;

   // Interrupt mask register, written at BASE+4
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
      end else if (wr_en && (offset[2:0] == 3'd4)) begin
         mask_q <= wdata;
      end
   end

   assign mask_rd = mask_q;
   assign irq     = |((rise_q | fall_q) & mask_q);
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

   // Read mux: registers are zero-extended to the 32-bit bus
   always_comb begin
      rdata = '0;
      case (offset[2:0])
         3'd0:    rdata[WIDTH-1:0] = stable_q;
         3'd1:    rdata[15:0]      = period_q;
         3'd2:    rdata[WIDTH-1:0] = rise_q;
         3'd3:    rdata[WIDTH-1:0] = fall_q;
         3'd4:    rdata[WIDTH-1:0] = mask_rd;
         default: rdata            = '0;
      endcase
   end

   assign data_bus_data = rd_en ? rdata : 'z;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner
// Self-checking bench: expected values are queued when stimulus is driven and
// popped when the DUT output is sampled. The bus is pulled high, so an
// undriven (Z) bus reads back as 32'hFFFFFFFF.
module tb_gpio_input_conditioner;

   localparam int          WIDTH = 16;
   localparam logic [31:0] BASE  = 32'h4034;
   localparam logic [31:0] ZVAL  = 32'hFFFF_FFFF;

   logic              clk;
   logic              reset;
   logic [WIDTH-1:0]  pins_raw;
   logic [WIDTH-1:0]  pins_clean;
   tri1  [31:0]       data_bus_data;
   logic [31:0]       data_bus_addr;
   logic [1:0]        data_bus_mode;
   logic              irq;
   logic [31:0]       tb_drv;
   logic              tb_oe;

   int numChecks;
   int numFails;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   exp_t expQ[$];

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic [31:0] addr;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs[9];

   assign data_bus_data = tb_oe ? tb_drv : 'z;

   gpio_input_conditioner #(
      .WIDTH(WIDTH),
      .BASE_ADDR(BASE),
      .DEFAULT_PERIOD(16'd1000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pins_raw(pins_raw),
      .pins_clean(pins_clean),
      .data_bus_data(data_bus_data),
      .data_bus_addr(data_bus_addr),
      .data_bus_mode(data_bus_mode),
      .irq(irq)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic expectValue(input string name, input logic [31:0] value);
      exp_t e;
      e.name  = name;
      e.value = value;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] actual);
      exp_t e;
      numChecks++;
      if (expQ.size() == 0) begin
         numFails++;
         $display("[TB] FAIL scoreboard: got %h expected queued value", actual);
      end else begin
         e = expQ.pop_front();
         if (actual !== e.value) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.value);
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] addr);
      data_bus_mode = mode;
      data_bus_addr = addr;
   endtask

   task automatic stepEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(2'b10, addr);
      tb_drv = data;
      tb_oe  = 1'b1;
      @(posedge clk);
      #1;
      tb_oe = 1'b0;
      applyStimulus(2'b00, 32'h0);
   endtask

   task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
      expectValue(name, expected);
      applyStimulus(2'b01, addr);
      #1;
      checkOutput(data_bus_data);
      applyStimulus(2'b00, 32'h0);
   endtask

   task automatic pinsCheck(input string name, input logic [WIDTH-1:0] expected);
      expectValue(name, {16'h0, expected});
      checkOutput({16'h0, pins_clean});
   endtask

   task automatic irqCheck(input string name, input logic expected);
      expectValue(name, {31'h0, expected});
      checkOutput({31'h0, irq});
   endtask

   // Main test sequence
   initial begin
      numChecks     = 0;
      numFails      = 0;
      reset         = 1'b0;
      pins_raw      = '0;
      data_bus_addr = '0;
      data_bus_mode = 2'b00;
      tb_drv        = '0;
      tb_oe         = 1'b0;

      vecs[0] = '{"rst_state",   2'b01, BASE + 0, 32'h0000_0000};
      vecs[1] = '{"rst_period",  2'b01, BASE + 1, 32'h0000_03E8};
      vecs[2] = '{"rst_rise",    2'b01, BASE + 2, 32'h0000_0000};
      vecs[3] = '{"rst_fall",    2'b01, BASE + 3, 32'h0000_0000};
      vecs[4] = '{"rst_mask",    2'b01, BASE + 4, 32'h0000_0000};
      vecs[5] = '{"z_above",     2'b01, BASE + 5, ZVAL};
      vecs[6] = '{"z_below",     2'b01, BASE - 1, ZVAL};
      vecs[7] = '{"z_idle",      2'b00, BASE + 1, ZVAL};
      vecs[8] = '{"z_mode11",    2'b11, BASE + 1, ZVAL};

      stepEdges(3);
      reset = 1'b1;
      stepEdges(1);

      // Reset values and bus decode
      for (int i = 0; i < 9; i++) begin
         expectValue(vecs[i].name, vecs[i].expected);
         applyStimulus(vecs[i].mode, vecs[i].addr);
         #1;
         checkOutput(data_bus_data);
      end
      applyStimulus(2'b00, 32'h0);
      pinsCheck("rst_pins_clean", 16'h0000);
      irqCheck("rst_irq", 1'b0);

      // PERIOD=4, pin0 rises: pins_clean changes at edge 7
      busWrite(BASE + 1, 32'd4);
      readCheck("period_4", BASE + 1, 32'd4);
      pins_raw[0] = 1'b1;
      stepEdges(6);
      pinsCheck("p0_edge6", 16'h0000);
      readCheck("rise_edge6", BASE + 2, 32'h0);
      stepEdges(1);
      pinsCheck("p0_edge7", 16'h0001);
      readCheck("state_edge7", BASE + 0, 32'h1);
      readCheck("rise_edge7", BASE + 2, 32'h1);
      busWrite(BASE + 2, 32'h0);
      readCheck("rise_w0", BASE + 2, 32'h1);
      busWrite(BASE + 2, 32'h1);
      readCheck("rise_w1c", BASE + 2, 32'h0);

      // Three-cycle glitch on pin3 is filtered
      pins_raw[3] = 1'b1;
      stepEdges(3);
      pins_raw[3] = 1'b0;
      stepEdges(10);
      pinsCheck("glitch_pins", 16'h0001);
      readCheck("glitch_rise", BASE + 2, 32'h0);
      readCheck("glitch_fall", BASE + 3, 32'h0);

      // Rewriting PERIOD mid-count restarts pin7's count
      pins_raw[7] = 1'b1;
      stepEdges(5);
      busWrite(BASE + 1, 32'd4);
      stepEdges(4);
      pinsCheck("restart_edge10", 16'h0001);
      stepEdges(1);
      pinsCheck("restart_edge11", 16'h0081);
      readCheck("restart_rise", BASE + 2, 32'h80);
      busWrite(BASE + 2, 32'hFFFF);

      // PERIOD=0: pin5 falls at edge 3
      busWrite(BASE + 1, 32'd0);
      pins_raw[5] = 1'b1;
      stepEdges(5);
      pinsCheck("p5_high", 16'h00A1);
      readCheck("p5_rise", BASE + 2, 32'h20);
      busWrite(BASE + 2, 32'h20);
      pins_raw[5] = 1'b0;
      stepEdges(2);
      pinsCheck("p5_edge2", 16'h00A1);
      stepEdges(1);
      pinsCheck("p5_edge3", 16'h0081);
      readCheck("p5_fall", BASE + 3, 32'h20);
      busWrite(BASE + 3, 32'hFFFF);
      readCheck("fall_cleared", BASE + 3, 32'h0);

      // Clear of RISE[2] on the very edge it is captured: set wins
      pins_raw[2] = 1'b1;
      stepEdges(2);
      busWrite(BASE + 2, 32'h4);
      pinsCheck("p2_high", 16'h0085);
      readCheck("set_wins", BASE + 2, 32'h4);
      busWrite(BASE + 2, 32'h4);
      readCheck("p2_cleared", BASE + 2, 32'h0);
      busWrite(BASE + 0, 32'hFFFF);
      readCheck("state_ro", BASE + 0, 32'h85);

`ifdef GPIO_COND_IRQ_EN
      // Masked capture raises irq, clearing drops it, unmasked capture does not
      busWrite(BASE + 4, 32'h2);
      readCheck("mask_rd", BASE + 4, 32'h2);
      pins_raw[1] = 1'b1;
      stepEdges(2);
      irqCheck("irq_before", 1'b0);
      stepEdges(1);
      irqCheck("irq_set", 1'b1);
      readCheck("p1_rise", BASE + 2, 32'h2);
      busWrite(BASE + 2, 32'h2);
      irqCheck("irq_cleared", 1'b0);
      busWrite(BASE + 4, 32'h0);
      pins_raw[1] = 1'b0;
      stepEdges(3);
      readCheck("p1_fall", BASE + 3, 32'h2);
      irqCheck("irq_unmasked", 1'b0);
`else
      // Without the irq feature MASK reads 0 and irq never rises
      busWrite(BASE + 4, 32'hFFFF);
      readCheck("mask_absent", BASE + 4, 32'h0);
      pins_raw[1] = 1'b1;
      stepEdges(3);
      readCheck("p1_rise", BASE + 2, 32'h2);
      irqCheck("irq_tied", 1'b0);
`endif

      if (expQ.size() != 0) begin
         numFails++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits between the physical GPIO pins and the GPIO port's input path.
- Synchronises and debounces each input pin and feeds the clean levels to the port as pins_clean.
- Latches per-pin rising and falling edges into memory-mapped capture registers.
- Optionally raises a level interrupt.
- Attaches to the shared data bus using the same protocol as the other peripherals: mode 00 idle, 01 read, 10 write.

Parameters:
- WIDTH, 16, number of conditioned pins (1..32).
- BASE_ADDR, 32'h4034, word address of the first register.
- DEFAULT_PERIOD, 16'd1000, reset value of the PERIOD register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pins_raw  input  WIDTH  asynchronous pin levels.
- pins_clean  output  WIDTH  debounced levels, forwarded to the GPIO port.
- data_bus_data  inout  32  shared bus data; driven only during a decoded read, otherwise Z.
- data_bus_addr  input  32  bus word address.
- data_bus_mode  input  2  00 idle, 01 read, 10 write.
- irq  output  1  level interrupt; constant 0 unless GPIO_COND_IRQ_EN is defined.

Behaviour:
- Register map (unused bits read 0):
  - BASE+0 STATE: RO, the current debounced levels.
  - BASE+1 PERIOD: RW, bits [15:0].
  - BASE+2 RISE: read / write-1-to-clear.
  - BASE+3 FALL: read / write-1-to-clear.
  - BASE+4 MASK: RW.
- Reset (async, active-low): sync stages 0, stable 0, all counters 0, RISE/FALL 0, MASK 0, PERIOD=DEFAULT_PERIOD. Outputs: pins_clean=0, irq=0, data_bus_data=Z.
- Synchroniser: two flops per pin; sync_q is the second stage.
- Debounce, per pin, each edge:
  - If sync_q==stable: cnt<=0.
  - Else if cnt>=PERIOD: stable<=sync_q and cnt<=0.
  - Else cnt<=cnt+1.
  - cnt is 16 bits and saturates rather than wrapping.
- Latency: count the edge that first samples a new, steady pin level as edge 1. stable and pins_clean change at edge PERIOD+3.
  - PERIOD=0: change at edge 3 (synchroniser plus one cycle).
- Glitch filtering: a level that returns to stable before its count completes clears cnt and produces no output change.
- Writing PERIOD clears all counters in the same edge. Pending transitions restart their count under the new period.
- Edge capture:
  - RISE[i] sets on the edge where stable[i] goes 0->1; FALL[i] sets on 1->0.
  - Bits remain set until cleared by a write-1. Writing 0 has no effect.
  - Set and clear in the same edge: set wins.
- Pin held high through reset: RISE is set PERIOD+3 edges after reset release. This is intentional; software clears it during init.
- Bus read:
  - Drive data_bus_data combinationally while mode==01 and BASE<=addr<=BASE+4; otherwise Z.
  - Reads have no side effects.
- Bus write:
  - Sampled at the clock edge while mode==10 and addr is in range.
  - Writes to STATE are ignored.
  - PERIOD takes data[15:0]; MASK takes data[WIDTH-1:0].
- Mode 11 is treated as idle.
- Write and capture interaction: same-edge rule above applies.

Optional Feature:
- Macro: GPIO_COND_IRQ_EN.
- Defined:
  - irq = |((RISE|FALL) & MASK), combinational from registered state.
  - irq is therefore high in the cycle after the capturing edge.
  - irq stays high until the bits are cleared or masked.
- Undefined:
  - irq is tied to 0.
  - MASK storage is removed; BASE+4 still decodes, reads 0 and ignores writes.
  - All other behaviour is identical.

Test Plan:
- Reset, then read BASE+1 -> 0x000003E8; read BASE+0 -> 0; irq=0; data_bus_data is Z while mode=00.
- Write PERIOD=4, drive pins_raw[0] 0->1 and hold -> pins_clean[0] rises at edge 7. RISE reads 0x1. Write 0x1 to BASE+2 -> RISE reads 0.
- PERIOD=4, pulse pins_raw[3] high for 3 cycles -> pins_clean and FALL/RISE stay 0.
- PERIOD=0, drive pins_raw[5] 1->0 with stable=1 -> pins_clean[5]=0 at edge 3; FALL=0x20.
- Hold write-1 to BASE+2 bit 2 during the edge where stable[2] rises -> RISE[2] remains 1.
- With GPIO_COND_IRQ_EN: MASK=0x2, pin1 rises -> irq=1 the cycle after capture. Clear FALL/RISE -> irq=0. Repeat with MASK=0 -> irq stays 0.
